// File: rtl/ws2812_encoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812_encoder_pkg
//  Description : Shared state encoding and default 25 MHz bit timing for the
//                WS2812 serial encoder, so the LED controller and the encoder
//                agree on one set of numbers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_encoder_pkg;

    // Encoder states; encoding fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Default timing at a 25 MHz clock (40 ns per cycle).
    localparam int unsigned c_t0h_cyc_dflt   = 10;    // 400 ns
    localparam int unsigned c_t1h_cyc_dflt   = 20;    // 800 ns
    localparam int unsigned c_tbit_cyc_dflt  = 31;    // 1.24 us
    localparam int unsigned c_reset_cyc_dflt = 1500;  // 60 us latch

    // Index of the first bit on the wire (GRB, MSB first).
    localparam logic [4:0] c_first_bit_idx = 5'd23;

endpackage
`default_nettype wire

// File: rtl/ws2812_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812_encoder_if
//  Description : Pixel stream handshake into the WS2812 encoder
//                (pixel, last flag, valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ws2812_encoder_if;
    logic [23:0] pixel_i;   // GRB, bit 23 sent first
    logic        last_i;    // final pixel of the frame
    logic        valid_i;
    logic        ready_o;

    // Pixel source (frame logic)
    modport master (output pixel_i, output last_i, output valid_i, input ready_o);
    // Encoder side
    modport slave  (input pixel_i, input last_i, input valid_i, output ready_o);
endinterface
`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812_bit_timer
//  Description : Times one WS2812 bit cell. Owns the phase counter, reports
//                the line level for the current phase and strobes on the last
//                cycle of each cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_bit_timer #(
    parameter int unsigned T0H_CYC  = 10,
    parameter int unsigned T1H_CYC  = 20,
    parameter int unsigned TBIT_CYC = 31
) (
    input  wire logic clk,
    input  wire logic reset,         // synchronous, active low
    input  wire logic run_i,         // bit cells are being emitted
    input  wire logic start_i,       // restart the cell at phase 0
    input  wire logic bit_i,         // value of the current bit
    output logic      level_o,       // line level for this phase
    output logic      end_of_bit_o   // last cycle of the cell
);

    localparam int unsigned    c_pw       = $clog2(TBIT_CYC);
    localparam logic [c_pw-1:0] c_t0h     = c_pw'(T0H_CYC);
    localparam logic [c_pw-1:0] c_t1h     = c_pw'(T1H_CYC);
    localparam logic [c_pw-1:0] c_last_ph = c_pw'(TBIT_CYC - 1);

    logic [c_pw-1:0] phase_cnt_q;
    logic [c_pw-1:0] phase_cnt_d;

    // Line level and cell-end strobe from the current phase.
    always_comb begin
        end_of_bit_o = run_i && (phase_cnt_q == c_last_ph);
        level_o      = run_i && (phase_cnt_q < (bit_i ? c_t1h : c_t0h));
    end

    // Phase advance: wraps at the cell end so consecutive cells abut.
    always_comb begin
        phase_cnt_d = phase_cnt_q + c_pw'(1);
        if (!run_i || start_i || end_of_bit_o) begin
            phase_cnt_d = '0;
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_cnt_q <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812_encoder
//  Description : Serialises 24-bit GRB pixels into the WS2812 single-wire NRZ
//                waveform and closes each frame with a low latch period.
//                Optional macro WS2812_UNDERRUN_CNT_EN adds a saturating
//                8-bit count of frames truncated by a missing pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_encoder
    import ws2812_encoder_pkg::*;
#(
    parameter int unsigned T0H_CYC   = c_t0h_cyc_dflt,
    parameter int unsigned T1H_CYC   = c_t1h_cyc_dflt,
    parameter int unsigned TBIT_CYC  = c_tbit_cyc_dflt,
    parameter int unsigned RESET_CYC = c_reset_cyc_dflt
) (
    input  wire logic            clk,
    input  wire logic            reset,   // synchronous, active low
    ws2812_encoder_if.slave      pix,
    output logic                 led_o,
    output logic                 busy_o,
    output logic                 done_o
`ifdef WS2812_UNDERRUN_CNT_EN
    , output logic [7:0]         underrun_cnt_o
`endif
);

    localparam int unsigned     c_lw         = $clog2(RESET_CYC + 1);
    localparam logic [c_lw-1:0] c_latch_last = c_lw'(RESET_CYC - 1);

    state_e           state_q, state_d;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic             last_q, last_d;
    logic [c_lw-1:0]  latch_cnt_q, latch_cnt_d;
    logic             led_q, led_d;

    logic             w_accept_ok;
    logic             w_start_bit;
    logic             w_level;
    logic             w_end_of_bit;

    ws2812_bit_timer #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_timer (
        .clk          (clk),
        .reset        (reset),
        .run_i        (state_q == SHIFT),
        .start_i      (w_start_bit),
        .bit_i        (shift_q[23]),
        .level_o      (w_level),
        .end_of_bit_o (w_end_of_bit)
    );

    // Next-state logic: pixel loading, bit stepping, frame end and latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        last_d      = last_q;
        latch_cnt_d = latch_cnt_q;
        w_accept_ok = 1'b0;
        w_start_bit = 1'b0;
        unique case (state_q)
            IDLE: begin
                w_accept_ok = 1'b1;
                latch_cnt_d = '0;
                if (pix.valid_i) begin
                    shift_d     = pix.pixel_i;
                    last_d      = pix.last_i;
                    bit_idx_d   = c_first_bit_idx;
                    w_start_bit = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (w_end_of_bit) begin
                    if (bit_idx_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q - 5'd1;
                    end else if (last_q) begin
                        state_d     = LATCH;
                        latch_cnt_d = '0;
                    end else begin
                        // Pixel boundary: the next pixel must be here now,
                        // otherwise the frame is cut short (never stalled).
                        w_accept_ok = 1'b1;
                        if (pix.valid_i) begin
                            shift_d   = pix.pixel_i;
                            last_d    = pix.last_i;
                            bit_idx_d = c_first_bit_idx;
                        end else begin
                            state_d     = LATCH;
                            latch_cnt_d = '0;
                        end
                    end
                end
            end
            LATCH: begin
                if (latch_cnt_q == c_latch_last) begin
                    state_d     = IDLE;
                    latch_cnt_d = '0;
                end else begin
                    latch_cnt_d = latch_cnt_q + c_lw'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        led_d = w_level;
    end

    // State, datapath and registered line output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            last_q      <= 1'b0;
            latch_cnt_q <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            last_q      <= last_d;
            latch_cnt_q <= latch_cnt_d;
            led_q       <= led_d;
        end
    end

    // ready is held low while reset is asserted, even though state is IDLE.
    assign pix.ready_o = w_accept_ok && reset;
    assign led_o       = led_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == LATCH) && (latch_cnt_q == c_latch_last);

`ifdef WS2812_UNDERRUN_CNT_EN
    logic       w_underrun_evt;
    logic [7:0] underrun_cnt_q, underrun_cnt_d;

    // Underrun counter: one count per truncated frame, saturating.
    always_comb begin
        w_underrun_evt = (state_q == SHIFT) && w_end_of_bit && (bit_idx_q == 5'd0)
                         && !last_q && !pix.valid_i;
        underrun_cnt_d = underrun_cnt_q;
        if (w_underrun_evt && (underrun_cnt_q != 8'hFF)) begin
            underrun_cnt_d = underrun_cnt_q + 8'd1;
        end
    end

    // Underrun counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            underrun_cnt_q <= 8'd0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule
`default_nettype wire
